// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART RX and TX sides.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    localparam int UART_DATA_W   = 8;
    localparam int UART_BAUD_DIV = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with valid/ready output and count-based full/empty.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   push, pop;

    assign out_valid = cnt_q != '0;
    assign out_data  = mem_q[rd_q];

    // A pop frees the head slot this cycle, so a full FIFO still accepts a push.
    always_comb begin
        pop      = out_valid & out_ready;
        in_ready = (cnt_q != (AW+1)'(DEPTH)) | pop;
        push     = in_valid & in_ready;
        mem_d    = mem_q;
        if (push) mem_d[wr_q] = in_data;
        rd_d     = pop  ? rd_q + 1'b1 : rd_q;
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with synchroniser and valid/ready byte output.
// Define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO instead of one register.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_BAUD_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_in,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   rx_busy
);

    localparam int            BW      = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] HALF_LD = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_LD = BW'(BAUD_DIV - 1);

    if (BAUD_DIV < 8) begin : g_baud_chk
        $error("BAUD_DIV must be at least 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of two of at least 2");
    end

    uart_state_e            state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   s1_q, s2_q, prev_q;
    logic                   fe_q, fe_d, ov_q, ov_d;
    logic                   push, tick, start_edge;

    assign tick       = baud_q == '0;
    assign start_edge = prev_q & ~s2_q;
    assign rx_busy    = state_q != UART_IDLE;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? baud_q : baud_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            UART_IDLE: if (start_edge) begin
                bit_d   = '0;
                baud_d  = HALF_LD;
                state_d = UART_START;
            end
            UART_START: if (tick) begin
                baud_d  = FULL_LD;
                state_d = s2_q ? UART_IDLE : UART_DATA;
            end
            UART_DATA: if (tick) begin
                shift_d = {s2_q, shift_q[UART_DATA_W-1:1]};
                bit_d   = bit_q + 1'b1;
                baud_d  = FULL_LD;
                state_d = (bit_q == 3'd7) ? UART_STOP : UART_DATA;
            end
            default: if (tick) begin
                push    = s2_q;
                fe_d    = ~s2_q;
                state_d = UART_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            s1_q    <= rx_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_in_ready;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (shift_q),
        .in_valid (push),
        .in_ready (fifo_in_ready),
        .out_data (rx_data),
        .out_valid(rx_valid),
        .out_ready(rx_ready)
    );

    assign ov_d = push & ~fifo_in_ready;
`else
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d, accept;

    assign rx_data  = data_q;
    assign rx_valid = valid_q;

    // A same-cycle transfer empties the holding register, so the new byte still fits.
    always_comb begin
        accept  = push & (~valid_q | rx_ready);
        data_d  = accept ? shift_q : data_q;
        valid_d = accept | (valid_q & ~rx_ready);
        ov_d    = push & ~accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed self-checking bench for uart_rx_frontend at BAUD_DIV = 16.
// Covers the FIFO overrun scenario when UART_RX_FIFO_EN is defined, the holding-register one otherwise.
module tb_uart_rx_frontend;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, rx_busy;

    int errors = 0;
    int checks = 0;
    int vld_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] got_q [$];

    always #5 clk = ~clk;

    uart_rx_frontend #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always @(negedge clk) begin
        if (rx_valid) vld_cyc++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic send_bit(input logic v);
        rx_in = v;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_in = 1'b1; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte;
        int v0, f0, o0, n0;
        rx_ready = 1'b1;
        v0 = vld_cyc; f0 = fe_cnt; o0 = ov_cnt; n0 = got_q.size();
        send_byte(8'hA5, 1'b1);
        checks++; if (vld_cyc - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=1", vld_cyc - v0); end
        checks++; if (got_q.size() - n0 !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got_q.size() - n0); end
        checks++; if (got_q[n0] !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", got_q[n0]); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL single_fe got=%0d exp=0", fe_cnt - f0); end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL single_ov got=%0d exp=0", ov_cnt - o0); end
    endtask

    task automatic test_false_start;
        int v0, f0;
        v0 = vld_cyc; f0 = fe_cnt;
        rx_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_busy_high got=%b exp=1", rx_busy); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_busy_low got=%b exp=0", rx_busy); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (vld_cyc - v0 !== 0) begin errors++; $display("FAIL false_valid got=%0d exp=0", vld_cyc - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL false_fe got=%0d exp=0", fe_cnt - f0); end
    endtask

    task automatic test_frame_err;
        int v0, f0, n0;
        rx_ready = 1'b1;
        v0 = vld_cyc; f0 = fe_cnt;
        send_byte(8'h3C, 1'b0);
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL frame_fe got=%0d exp=1", fe_cnt - f0); end
        checks++; if (vld_cyc - v0 !== 0) begin errors++; $display("FAIL frame_valid got=%0d exp=0", vld_cyc - v0); end
        n0 = got_q.size();
        send_byte(8'h55, 1'b1);
        checks++; if (got_q.size() - n0 !== 1) begin errors++; $display("FAIL frame_next_count got=%0d exp=1", got_q.size() - n0); end
        checks++; if (got_q[n0] !== 8'h55) begin errors++; $display("FAIL frame_next_data got=%h exp=55", got_q[n0]); end
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL frame_next_fe got=%0d exp=1", fe_cnt - f0); end
    endtask

`ifdef UART_RX_FIFO_EN
    task automatic test_overrun;
        int o0;
        rx_ready = 1'b0;
        o0 = ov_cnt;
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL fifo_ov_early got=%0d exp=0", ov_cnt - o0); end
        checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL fifo_head got=%h exp=01", rx_data); end
        send_byte(8'h05, 1'b1);
        checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL fifo_ov got=%0d exp=1", ov_cnt - o0); end
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i + 1)) begin
                errors++;
                $display("FAIL fifo_drain%0d got=%b/%h exp=1/%h", i, rx_valid, rx_data, 8'(i + 1));
            end
        end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got=%b exp=0", rx_valid); end
        @(posedge clk);
        #1;
    endtask
`else
    task automatic test_overrun;
        int o0, n0;
        rx_ready = 1'b0;
        o0 = ov_cnt;
        send_byte(8'h11, 1'b1);
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL hold_ov_first got=%0d exp=0", ov_cnt - o0); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL hold_first got=%b/%h exp=1/11", rx_valid, rx_data); end
        send_byte(8'h22, 1'b1);
        checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL hold_ov got=%0d exp=1", ov_cnt - o0); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL hold_kept got=%b/%h exp=1/11", rx_valid, rx_data); end
        n0 = got_q.size();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL hold_drained got=%b exp=0", rx_valid); end
        checks++; if (got_q.size() - n0 !== 1 || got_q[n0] !== 8'h11) begin errors++; $display("FAIL hold_pop got=%0d/%h exp=1/11", got_q.size() - n0, got_q[n0]); end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int n0;
        rx_ready = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", rx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_err got=%b/%b exp=0/0", frame_err, overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", rx_busy); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n0 = got_q.size();
        send_byte(8'h0F, 1'b1);
        checks++; if (got_q.size() - n0 !== 1) begin errors++; $display("FAIL mid_next_count got=%0d exp=1", got_q.size() - n0); end
        checks++; if (got_q[n0] !== 8'h0F) begin errors++; $display("FAIL mid_next_data got=%h exp=0f", got_q[n0]); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Receive front end for the SoC UART debug/load port. Takes the raw asynchronous serial pin (pad `ui_in[0]`), synchronises it, decodes 8N1 frames at a fixed clocks-per-bit rate, and presents received bytes to the core-side UART command logic over a valid/ready stream. It sits between the top-level pad wiring and the UART consumer inside `fpga_top`, and reports framing and overrun errors as single-cycle pulses.

## Interface
- `BAUD_DIV`, default 434: clocks per bit, minimum 8. The default gives 50 MHz / 115200.
- `FIFO_DEPTH`, default 4: byte buffer depth, a power of two. Used only when the FIFO is compiled in.
- `clk`  in  1  system clock. One clock domain only.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rx_in`  in  1  raw serial line, asynchronous, idle high.
- `rx_data`  out  8  received byte, LSB = first data bit.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte; transfer occurs when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped because storage was full.
- `rx_busy`  out  1  the FSM is not in IDLE.

## Operation
- **Synchroniser.**
  - Two flops on `rx_in`, both reset to 1. A third flop holds the previous synchronised value for edge detection.
  - A start is detected on a synchronised 1→0 edge.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: on a start edge, load `bit_cnt` = 0 and `baud_cnt` = `BAUD_DIV/2 - 1`, then go to START.
  - START: when `baud_cnt` reaches 0, sample the line. If it is 1, this is a false start: return to IDLE with no output. If it is 0, reload `baud_cnt` = `BAUD_DIV-1` and go to DATA.
  - DATA: at each `baud_cnt` = 0, shift the sample into bit 7 of the shift register (LSB-first) and increment `bit_cnt`. After the 8th sample go to STOP, reloading `baud_cnt`.
  - STOP: at `baud_cnt` = 0, sample the line.
    - Sample is 1: push the byte, pulsing `overrun` instead if storage is full.
    - Sample is 0: pulse `frame_err` and discard the byte.
    - In both cases go to IDLE.
  - After a STOP with a low sample, a new start needs a fresh 1→0 edge. A held break therefore yields exactly one `frame_err`.
- **Counters.**
  - `baud_cnt` width is `$clog2(BAUD_DIV)` and it counts down.
  - `bit_cnt` is 3 bits.
- **Output stream.** `rx_data` stays stable while `rx_valid` is high and `rx_ready` is low. Once asserted, `rx_valid` does not drop without a transfer.
- **Full with simultaneous pop and push.** The push is accepted, the occupancy is unchanged, and no `overrun` is signalled.
- **Reset mid-frame.** Asynchronous reset returns the FSM to IDLE, empties storage, and drives all outputs to reset values. A frame in progress is lost.
- **Reset values:** `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `rx_busy` = 0.

## Timing
- Latency from the raw start edge to the START decision is 2 synchroniser cycles, 1 edge-detect cycle, then `BAUD_DIV/2` cycles.
- Bit n is sampled at edge + 3 + `BAUD_DIV/2` + (n+1)·`BAUD_DIV` cycles, giving mid-bit sampling.
- `rx_valid` rises on the cycle after the stop-bit sample when storage was empty.
- `frame_err` and `overrun` are registered and rise on the cycle after the stop-bit sample.
- `rx_busy` is high from the cycle after the start edge through the stop-sample cycle.
- With the FIFO in, a pop in cycle t leaves the next entry on `rx_data` in cycle t+1. There is no bubble.

## Configuration
- `UART_RX_FIFO_EN` defined: a `FIFO_DEPTH`-entry FIFO buffers bytes. `rx_data` is driven from the FIFO head register. `overrun` fires only when all `FIFO_DEPTH` entries are occupied.
- Undefined: a single holding register replaces the FIFO, and `FIFO_DEPTH` is ignored. `overrun` fires whenever a byte completes while `rx_valid` is high without a same-cycle transfer.

## Structure
- Shared package `uart_pkg`:
  - the FSM state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`);
  - `UART_DATA_W` = 8;
  - the default `BAUD_DIV` localparam, which is shared with the TX side.
- Sub-module `uart_rx_fifo`: a synchronous FIFO with valid/ready output, count-based full/empty, and pointers that wrap modulo `FIFO_DEPTH`. It is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
All scenarios run with `BAUD_DIV` = 16.
- **Single byte:** send 0xA5 in 8N1 with `rx_ready` = 1. `rx_data` = 0xA5, `rx_valid` high for exactly 1 cycle, no error pulses.
- **False start:** a 5-cycle low glitch on an idle line. No `rx_valid`, no `frame_err`. `rx_busy` returns low by cycle 12.
- **Framing error:** send 0x3C with a low stop bit. One `frame_err` pulse, no `rx_valid`. A following valid 0x55 is received correctly.
- **Overrun with FIFO (`UART_RX_FIFO_EN`, depth 4):** send 0x01 to 0x05 with `rx_ready` = 0.
  - One `overrun` pulse occurs on byte 5.
  - Draining then yields 0x01, 0x02, 0x03, 0x04, back-to-back, one per cycle.
- **Overrun without FIFO:** send 0x11 then 0x22 with `rx_ready` = 0. `overrun` pulses on 0x22 and `rx_data` stays 0x11.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of 0xF0. All outputs are at reset values. A subsequent 0x0F is received intact.
